// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: opcode constants, the fetch FSM state type
// and small helpers used by the fetch stage.
package riscv_pkg;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // True when a byte address is not word aligned.
    function automatic logic word_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch address generator: holds fetch_pc, applies +4 or a word-aligned
// redirect, and flags redirects whose target was not word aligned.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_pc_next,
    output logic            misalign
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;

    // Next fetch address: redirect beats sequential advance; +4 wraps silently.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
            misalign_d = word_misaligned(redirect_target[1:0]);
        end else if (advance) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch address and misalign pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_pc      = fetch_pc_q;
    assign fetch_pc_next = fetch_pc_d;
    assign misalign      = misalign_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time,
// an instruction register for decode, and branch redirect with response drop.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    fetch_state_t    state_q, state_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;

    logic            advance_s;
    logic [XLEN-1:0] fetch_pc_s;
    logic [XLEN-1:0] fetch_pc_next_s;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .advance         (advance_s),
        .redirect        (branch_taken),
        .redirect_target (branch_target),
        .fetch_pc        (fetch_pc_s),
        .fetch_pc_next   (fetch_pc_next_s),
        .misalign        (misalign)
    );

    // FSM next state and instruction-register updates.
    // The request strobe is visible during the S_REQ cycle that follows the
    // one where it was decided, so a redirect seen while the strobe is high
    // already has a response coming and must drop it like S_WAIT does.
    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        advance_s     = 1'b0;
        if (branch_taken) begin
            instr_valid_d = 1'b0;
            if (((state_q == S_WAIT) && !imem_rvalid) ||
                ((state_q == S_REQ) && imem_req_q)) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (imem_rvalid) begin
                        instr_d       = imem_rdata;
                        pc_d          = fetch_pc_s;
                        instr_valid_d = 1'b1;
                        advance_s     = 1'b1;
                        state_d       = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (instr_valid_q && !stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d       = S_REQ;
                    instr_valid_d = 1'b0;
                    drop_d        = 1'b0;
                end
            endcase
        end
    end

    // Registered request strobe and address, derived from the next state.
    always_comb begin
        if (state_d == S_REQ) begin
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_next_s;
        end else begin
            imem_req_d  = 1'b0;
            imem_addr_d = imem_addr_q;
        end
    end

    // Fetch FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign pc          = pc_q;

endmodule
